// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared defaults and the skid-buffer occupancy encoding
package fifo_reader_pkg;
   localparam int FIFO_WIDTH_DEF = 16;
   localparam int CNT_WIDTH_DEF  = 32;
   typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_e;
endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry skid buffer with occupancy FSM, slot0 is the stream head
//   push/push_data : word arriving from the FIFO this cycle
//   m_valid/m_ready/m_data : stream master side
//   pop : beat accepted this cycle, lvl : current occupancy 0..2
module fifo_reader_skid
   import fifo_reader_pkg::*;
#(
   parameter int W = FIFO_WIDTH_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         m_ready,
   output logic         m_valid,
   output logic [W-1:0] m_data,
   output logic         pop,
   output logic [1:0]   lvl
);
   occ_e         occ_q, occ_d;
   logic [W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
   logic [1:0]   idx;
   assign lvl     = occ_q;
   assign m_valid = occ_q != OCC_EMPTY;
   assign m_data  = slot0_q;
   assign pop     = m_valid && m_ready;
   assign idx     = lvl - {1'b0, pop};
   always_comb begin
      slot0_d = pop ? slot1_q : slot0_q;
      slot1_d = slot1_q;
      // new word lands behind whatever survives this cycle's pop
      if (push && idx == 2'd0) slot0_d = push_data;
      if (push && idx != 2'd0) slot1_d = push_data;
      case (occ_q)
         OCC_EMPTY: occ_d = push ? OCC_ONE : OCC_EMPTY;
         OCC_ONE:   occ_d = (push && !pop) ? OCC_TWO : (!push && pop) ? OCC_EMPTY : OCC_ONE;
         OCC_TWO:   occ_d = (pop && !push) ? OCC_ONE : OCC_TWO;
         default:   occ_d = OCC_EMPTY;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q   <= OCC_EMPTY;
         slot0_q <= '0;
         slot1_q <= '0;
      end else begin
         occ_q   <= occ_d;
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
      end
   end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a 1-cycle-latency FIFO read port into a valid/ready stream
//   fifo_empty/fifo_underflow/fifo_data_out in, fifo_rd_en out : FIFO read side
//   m_valid/m_ready/m_data : stream master
//   rd_count/err_underflow : stats, live only with FIFO_READER_STATS_EN defined, else 0
module fifo_stream_reader
   import fifo_reader_pkg::*;
#(
   parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic                  err_underflow
);
   logic       rd_pending_q, rd_pending_d;
   logic       pop;
   logic [1:0] lvl;
   logic [2:0] credit;
   fifo_reader_skid #(.W(FIFO_WIDTH)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_pending_q),
      .push_data (fifo_data_out),
      .m_ready   (m_ready),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .pop       (pop),
      .lvl       (lvl)
   );
   // words held or in flight after this cycle; a new read is safe while that stays <= 1
   assign credit = {1'b0, lvl} + {2'b0, rd_pending_q} - {2'b0, pop};
   always_comb begin
      fifo_rd_en   = rst_n && !fifo_empty && credit <= 3'd1;
      rd_pending_d = fifo_rd_en;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_pending_q <= 1'b0;
      else rd_pending_q <= rd_pending_d;
   end
`ifdef FIFO_READER_STATS_EN
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 err_q, err_d;
   always_comb begin
      cnt_d = cnt_q + CNT_WIDTH'(pop);
      err_d = err_q || fifo_underflow;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   assign rd_count      = cnt_q;
   assign err_underflow = err_q;
`else
   logic unused_underflow;
   assign unused_underflow = fifo_underflow;
   assign rd_count         = '0;
   assign err_underflow    = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: FIFO model + scoreboard bench for fifo_stream_reader
module tb_fifo_stream_reader;
   logic        clk = 0, rst_n = 0;
   logic        fifo_empty, fifo_underflow = 0, fifo_rd_en;
   logic [15:0] fifo_data_out = 0, m_data;
   logic        m_valid, m_ready = 0;
   logic [31:0] rd_count;
   logic        err_underflow;
   int          total = 0, bad = 0;
   logic [15:0] mem[$];
   logic [15:0] exp_q[$];
   int          fifo_n = 0, reads = 0, pops = 0;
   logic        prev_stall = 0;
   logic [15:0] prev_data = 0;
   fifo_stream_reader dut (
      .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
      .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .rd_count(rd_count), .err_underflow(err_underflow)
   );
   always #5 clk = ~clk;
   assign fifo_empty = fifo_n == 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask
   // FIFO read port: registered data one cycle after rd_en
   always @(posedge clk) begin
      if (fifo_rd_en && mem.size() > 0) begin
         fifo_data_out <= mem.pop_front();
         fifo_n <= fifo_n - 1;
         reads++;
      end
   end
   always @(negedge clk) begin
      if (!rst_n) prev_stall = 0;
      else begin
         if (fifo_rd_en && fifo_empty) chk("rd_en_while_empty", 1, 0);
         if (reads - pops > 2) chk("outstanding", reads - pops, 2);
         if (prev_stall) chk("stall_stable", m_data, prev_data);
         if (m_valid && m_ready) begin
            chk("beat_has_exp", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("beat_data", m_data, exp_q.pop_front());
            pops++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask
   task automatic wr(input logic [15:0] w);
      mem.push_back(w);
      fifo_n++;
      exp_q.push_back(w);
   endtask
   task automatic enter_reset();
      rst_n = 0;
      #1;
      mem.delete();
      exp_q.delete();
      fifo_n = 0;
      reads = 0;
      pops = 0;
   endtask
   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < budget) begin
         tick();
         n++;
      end
      chk(tag, exp_q.size(), 0);
   endtask
   initial begin
      // reset values, FIFO preloaded but reads must stay off
      enter_reset();
      m_ready = 1;
      for (int i = 1; i <= 8; i++) wr(16'(i));
      tick();
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_rd_count", rd_count, 0);
      chk("rst_err", err_underflow, 0);
      // full throughput: valid from cycle 2, 8 beats with no gap
      rst_n = 1;
      #1;
      chk("tp_rd_en_c0", fifo_rd_en, 1);
      for (int c = 0; c <= 10; c++) begin
         chk("tp_valid", m_valid, (c >= 2 && c < 10) ? 1 : 0);
         tick();
      end
      chk("tp_beats", pops, 8);
      // backpressure: 2 reads while stalled, head held
      enter_reset();
      m_ready = 0;
      for (int i = 1; i <= 8; i++) wr(16'h0100 + 16'(i));
      tick();
      rst_n = 1;
      tick(10);
      chk("bp_reads", reads, 2);
      chk("bp_head", m_data, 16'h0101);
      chk("bp_valid", m_valid, 1);
      m_ready = 1;
      drain("bp_drain", 40);
      chk("bp_beats", pops, 8);
      // toggling ready, 16 words
      enter_reset();
      for (int i = 0; i < 16; i++) wr(16'h2000 + 16'(i * 3));
      tick();
      rst_n = 1;
      for (int n = 0; n < 80 && exp_q.size() != 0; n++) begin
         m_ready = n[0] == 0;
         tick();
      end
      m_ready = 1;
      drain("tog_drain", 10);
      chk("tog_beats", pops, 16);
      // single word, then a late write
      enter_reset();
      wr(16'hA5A5);
      tick();
      rst_n = 1;
      tick(5);
      chk("late_first", pops, 1);
      chk("late_gap", m_valid, 0);
      wr(16'h5A5A);
      #1;
      chk("late_rd_en", fifo_rd_en, 1);
      tick();
      chk("late_c1", m_valid, 0);
      tick();
      chk("late_c2", m_valid, 1);
      chk("late_c2_data", m_data, 16'h5A5A);
      drain("late_drain", 5);
      // reset while two words buffered
      enter_reset();
      m_ready = 0;
      for (int i = 1; i <= 4; i++) wr(16'h3000 + 16'(i));
      tick();
      rst_n = 1;
      tick(4);
      chk("mid_valid_pre", m_valid, 1);
      chk("mid_reads", reads, 2);
      rst_n = 0;
      #1;
      chk("mid_valid_async", m_valid, 0);
      chk("mid_data_async", m_data, 0);
      chk("mid_rd_en", fifo_rd_en, 0);
      exp_q.delete();
      foreach (mem[i]) exp_q.push_back(mem[i]);
      reads = 0;
      pops = 0;
      tick();
      rst_n = 1;
      m_ready = 1;
      tick(2);
      chk("mid_resume_head", m_data, 16'h3003);
      drain("mid_drain", 20);
      chk("mid_beats", pops, 2);
      // stats
      enter_reset();
      for (int i = 0; i < 20; i++) wr(16'h4000 + 16'(i));
      tick();
      rst_n = 1;
      drain("st_drain", 40);
      fifo_underflow = 1;
      tick();
      fifo_underflow = 0;
      tick(3);
`ifdef FIFO_READER_STATS_EN
      chk("st_count", rd_count, 20);
      chk("st_err_set", err_underflow, 1);
      enter_reset();
      chk("st_err_clr", err_underflow, 0);
      chk("st_count_clr", rd_count, 0);
`else
      chk("st_count_tied", rd_count, 0);
      chk("st_err_tied", err_underflow, 0);
`endif
      tick();
      rst_n = 1;
      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side drainer for the team's synchronous FIFO. It converts the FIFO's `rd_en`/`data_out`/`empty` interface, which has a one-cycle registered read latency, into a valid/ready streaming master. It holds a 2-entry skid buffer so full throughput (1 word/cycle) is sustained under downstream backpressure. It sits between the FIFO's read port and any consumer.

Parameters:
FIFO_WIDTH, 16, width of FIFO `data_out` and `m_data`
CNT_WIDTH, 32, width of delivered-word counter (optional feature only)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
fifo_empty  in  1  FIFO empty flag
fifo_underflow  in  1  FIFO underflow flag (read while empty)
fifo_data_out  in  FIFO_WIDTH  FIFO read data, valid the cycle after `fifo_rd_en`
fifo_rd_en  out  1  FIFO read request
m_valid  out  1  stream data valid
m_ready  in  1  consumer ready
m_data  out  FIFO_WIDTH  stream data
rd_count  out  CNT_WIDTH  words delivered (optional feature)
err_underflow  out  1  sticky underflow seen (optional feature)

Behaviour:
- Clock and reset: one clock, `clk`; `rst_n` asynchronous assert, active-low; released synchronously by the environment.
- Reset values:
  - `m_valid`=0, `m_data`=0, `rd_count`=0, `err_underflow`=0.
  - Internal occupancy `occ`=0, `rd_pending`=0.
  - `fifo_rd_en`=0 while `rst_n`=0.
- State:
  - `occ` ∈ {0,1,2} is the number of words in the skid buffer; slot0 is the head.
  - `rd_pending`=1 means a FIFO read was issued last cycle and data arrives this cycle.
- Occupancy is an explicit 3-state FSM:
  - EMPTY (occ=0)
  - ONE (occ=1)
  - TWO (occ=2)
- `pop` = `m_valid` && `m_ready`.
- `fifo_rd_en` = !`fifo_empty` && ((`occ` + `rd_pending` − `pop`) ≤ 1).
  - This is combinational from `m_ready` and `fifo_empty`; that path is intentional.
  - It must never assert while `fifo_empty`=1.
- Capture: when `rd_pending`=1, `fifo_data_out` is written at the clock edge into slot[`occ` − `pop`].
  - On simultaneous push and pop, slot1 shifts to slot0 and the new word lands behind it.
- Next-state update: `occ_next` = `occ` + `rd_pending` − `pop`; `rd_pending_next` = `fifo_rd_en`.
- Outputs:
  - `m_valid` = (`occ` != 0); registered state, no combinational path from inputs.
  - `m_data` = slot0.
  - `m_data` must be stable while `m_valid`=1 and `m_ready`=0.
- Latency: `fifo_rd_en` high in cycle N → word captured at the end of N+1 → `m_valid` high in N+2.
- Throughput: with `m_ready` held 1 and the FIFO non-empty, the steady state is `occ`=1, `rd_pending`=1, giving one word per cycle.
- Backpressure: `m_ready`=0 → at most 2 words buffered (`occ` + `rd_pending` never exceeds 2); no word is lost or duplicated.
- FIFO goes empty with a read in flight: the pending word is still captured; no further reads are issued.
- Words leave in exact FIFO order.
- Reset mid-operation: all state clears immediately, buffered and in-flight words are discarded, `m_valid` drops asynchronously.
- Consumer rule: `m_ready` may toggle freely; `m_valid` must never deassert without a `pop`.

Optional Feature:
`FIFO_READER_STATS_EN`
- Defined:
  - `rd_count` increments by 1 on each `pop` and wraps at 2^CNT_WIDTH.
  - `err_underflow` sets when `fifo_underflow`=1 on a clock edge and clears only on reset.
- Undefined: `rd_count` and `err_underflow` are tied to 0; the ports remain present.

Decomposition:
- Package `fifo_reader_pkg`:
  - Constants `FIFO_WIDTH_DEF`=16, `CNT_WIDTH_DEF`=32.
  - `typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_e`.
- Sub-module `fifo_reader_skid`:
  - Contains the 2-entry buffer, occupancy FSM and push/pop logic.
  - The top level holds the `fifo_rd_en` credit logic, `rd_pending` and the stats.

Test Plan:
- Reset then FIFO preloaded with 0x0001..0x0008, `m_ready`=1 → `fifo_rd_en` high from cycle 0; `m_valid` from cycle 2; 8 consecutive beats 0x0001..0x0008, no gaps.
- Same preload, `m_ready`=0 for 10 cycles then 1 → exactly 2 reads issued while stalled; `m_data`=0x0001 held stable; 8 beats delivered in order after release.
- `m_ready` toggling 1,0,1,0 with 16 words → all 16 delivered in order; `fifo_rd_en` never high with `fifo_empty`=1; `occ` + `rd_pending` ≤ 2 checked every cycle.
- FIFO holding 1 word, then a write arrives 5 cycles later → word0 out, `m_valid` drops, second word appears 2 cycles after `fifo_empty` falls.
- `rst_n` pulled low while `occ`=2 → `m_valid`=0 immediately; after release, the stream resumes from the next FIFO word with no stale beat.
- With `FIFO_READER_STATS_EN`: 20 pops → `rd_count`=20; force a `fifo_underflow` pulse → `err_underflow`=1 stays set until reset.
